genius_seq_gen: RTL
===================

// Module: genius_seq_gen
// PURPOSE
//  Parametrised colour-sequence engine for the Genius game. Fills an internal
//  DEPTH-entry sequence memory, either from the fixed 16-step table or from an
//  LFSR, then replays a prefix as timed one-hot colour flashes. The game FSM
//  uses rd_addr/rd_data to check player input and play_* to show the round.
// PARAMETERS
//  N_COLORS  4       one-hot colour width; legal values 2, 4, 8; CW=$clog2(N_COLORS)
//  DEPTH     32      sequence memory entries (>=2); AW=$clog2(DEPTH)
//  LFSR_W    16      LFSR width (fixed to 16 in this generation)
//  SEED      16'hACE1 LFSR reset value; also replaces any loaded seed of 0
//  T_ON      4       cycles a colour is driven per playback step (>=1)
//  T_OFF     2       dark cycles after each playback step (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  mode       in   1         0 = fixed table, 1 = LFSR random; sampled on gen_start
//  seed_load  in   1         load seed into the LFSR this cycle
//  seed       in   LFSR_W    seed value
//  gen_start  in   1         pulse: regenerate the whole memory
//  gen_busy   out  1         high while filling
//  gen_done   out  1         one-cycle pulse when the fill completes
//  rd_addr    in   AW        read address
//  rd_data    out  N_COLORS  one-hot colour at rd_addr (combinational)
//  play_start in   1         pulse: replay steps 0..play_len-1
//  play_len   in   AW+1      number of steps to replay
//  play_stop  in   1         abort playback
//  play_busy  out  1         high during playback
//  play_color out  N_COLORS  colour being flashed; 0 when dark or idle
//  play_step  out  AW        index of the current step
//  play_done  out  1         one-cycle pulse after the last dark phase
// BEHAVIOUR
//  Reset: memory all zero, LFSR=SEED, both FSMs idle, every output 0.
//  LFSR: Galois, taps 16'hB400, advances every cycle. seed_load has priority
//  over advance; a seed of 0 loads SEED. Colour index = lfsr[CW-1:0].
//  Gen FSM G_IDLE->G_FILL: accepts gen_start only when both FSMs are idle.
//  - Latches mode. Writes entry 0 on the next cycle, then one entry per cycle.
//  - Writes entry i at cycle i after the accept edge.
//  - Entry i = onehot(SEQ_FIXED[i%16]) (mode 0) or onehot(lfsr[CW-1:0]) (mode 1).
//  - After entry DEPTH-1: back to G_IDLE; gen_done pulses for one cycle.
//  - gen_start is ignored while busy. seed_load while busy changes later entries.
//  rd_data: mem[rd_addr]; forced to 0 while gen_busy or rd_addr>=DEPTH.
//  Play FSM P_IDLE->P_ON->P_OFF: accepts play_start only when P_IDLE and !gen_busy.
//  - Latches play_len; play_len>DEPTH is clamped to DEPTH.
//  - play_len==0: no flash; play_done pulses the next cycle.
//  - P_ON: play_color=mem[step] for T_ON cycles.
//  - P_OFF: play_color=0 for T_OFF cycles, then step++. Goes back to P_ON while
//    step<len; otherwise goes to P_IDLE and pulses play_done.
//  - First colour appears on the cycle after the accept edge.
//  - Total busy time = len*(T_ON+T_OFF) cycles.
//  - play_stop from any state: P_IDLE next cycle, play_color=0, step=0, no
//    play_done. play_stop wins over a simultaneous play_start.
//  - Simultaneous gen_start and play_start while idle: gen wins; play_start dropped.
//  Async reset mid-operation aborts immediately. Memory is cleared and no done
//  pulse is produced.
// STRUCTURE
//  Package genius_pkg holds:
//  - SEQ_FIXED[16] colour indices = {0,2,1,3,0,3,2,3,1,3,0,1,3,0,2,1}
//    (index k means one-hot bit k)
//  - LFSR_TAPS = 16'hB400
//  - gen_state_t {G_IDLE,G_FILL} and play_state_t {P_IDLE,P_ON,P_OFF}
//  - onehot() function
//  Sub-module genius_lfsr (clk, rst_n, load, seed, q): the LFSR, including the
//  zero-seed substitution.
// TESTING
//  1 mode=0, gen_start -> gen_busy for 32 cycles, then gen_done pulse;
//    rd_addr 0..3 -> 0001,0100,0010,1000; rd_addr 16 -> 0001; rd_addr 31 -> 0010.
//  2 seed_load seed=0 then gen mode=1, repeated with seed=16'hACE1 -> identical
//    memory contents; every entry one-hot, matching a bit-exact LFSR model.
//  3 after test 1, play_len=3, T_ON=4, T_OFF=2 -> play_color
//    0001x4,0x2,0100x4,0x2,0010x4,0x2; play_done at cycle 19; play_step 0,1,2.
//  4 play_len=0 -> play_done next cycle, play_color stays 0;
//    play_len=40 -> clamped to 32 steps.
//  5 play_stop during step 1 P_ON -> play_color=0 and play_busy=0 next cycle,
//    no play_done; gen_start during playback ignored.
//  6 rst_n low mid-fill and mid-play -> all outputs 0 asynchronously;
//    rd_data=0 for every address until the next fill.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius colour-sequence engine.
// Holds the fixed 16-step colour table, the LFSR tap mask, the state
// encodings of the fill and playback FSMs and the colour-index helpers.
package genius_pkg;

    // Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Colour indices of the fixed sequence; index k means one-hot bit k.
    localparam logic [1:0] SEQ_FIXED [16] = '{
        2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3,
        2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1
    };

    typedef enum logic [0:0] {
        G_IDLE = 1'b0,
        G_FILL = 1'b1
    } gen_state_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_ON   = 2'd1,
        P_OFF  = 2'd2
    } play_state_t;

    // One-hot decode of a colour index; wide enough for the largest palette,
    // callers size-cast the result down to N_COLORS bits.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // Colour index of fixed-table step k (k already reduced modulo 16).
    function automatic logic [2:0] fixed_idx(input logic [3:0] k);
        return {1'b0, SEQ_FIXED[k]};
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 16-bit Galois LFSR that advances every cycle.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset (loads SEED)
//   load  in  load seed this cycle; takes priority over advancing
//   seed  in  seed value; an all-zero seed is replaced by SEED so the
//             register can never lock up in the all-zero state
//   q     out current LFSR state
module genius_lfsr
    import genius_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = 16'hACE1,
    parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] q
);

    // LFSR state: seed load wins over the per-cycle Galois shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= (seed == {W{1'b0}}) ? SEED : seed;
        end else begin
            q <= {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : {W{1'b0}});
        end
    end

endmodule

// File: rtl/genius_seq_gen.sv
// Colour-sequence engine for the Genius game.
// Fills a DEPTH-entry one-hot colour memory from the fixed table (mode 0) or
// from the LFSR (mode 1), then replays steps 0..len-1 as timed flashes.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   mode                  0 fixed table, 1 LFSR; latched when a fill starts
//   seed_load, seed       reload the LFSR
//   gen_start             request a full memory fill
//   gen_busy, gen_done    fill in progress / one-cycle completion pulse
//   rd_addr, rd_data      combinational memory read (0 while filling)
//   play_start, play_len  request replay of play_len steps (clamped to DEPTH)
//   play_stop             abort replay, no done pulse
//   play_busy, play_color replay in progress / colour being flashed
//   play_step, play_done  current step index / one-cycle completion pulse
module genius_seq_gen
    import genius_pkg::*;
#(
    parameter int                N_COLORS = 4,
    parameter int                DEPTH    = 32,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter int                T_ON     = 4,
    parameter int                T_OFF    = 2,
    localparam int               AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                gen_start,
    output logic                gen_busy,
    output logic                gen_done,
    input  logic [AW-1:0]       rd_addr,
    output logic [N_COLORS-1:0] rd_data,
    input  logic                play_start,
    input  logic [AW:0]         play_len,
    input  logic                play_stop,
    output logic                play_busy,
    output logic [N_COLORS-1:0] play_color,
    output logic [AW-1:0]       play_step,
    output logic                play_done
);

    localparam int            LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam int            TMAX    = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int            TW      = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TON_L   = TW'(T_ON - 1);
    localparam logic [TW-1:0] TOFF_L  = TW'(T_OFF - 1);
    localparam logic [2:0]    CMASK   = 3'(N_COLORS - 1);

    gen_state_t            gen_state_r, gen_state_s;
    logic [AW-1:0]         wr_idx_r, wr_idx_s;
    logic                  gen_mode_r, gen_mode_s;
    logic                  gen_done_r, gen_done_s;
    logic                  gen_accept_s;
    logic                  mem_we_s;
    logic [N_COLORS-1:0]   wr_data_s;
    logic [N_COLORS-1:0]   mem_r [DEPTH];
    logic [LFSR_W-1:0]     lfsr_q_s;
    logic [2:0]            lfsr_col_s;
    logic [2:0]            fixed_col_s;
    logic                  addr_ok_s;

    play_state_t           play_state_r, play_state_s;
    logic [AW-1:0]         step_r, step_s, step_inc_s;
    logic [LW-1:0]         len_r, len_s, next_count_s;
    logic [TW-1:0]         timer_r, timer_s;
    logic [N_COLORS-1:0]   color_r, color_s;
    logic                  play_done_r, play_done_s;

    genius_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED),
        .TAPS (LFSR_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_load),
        .seed  (seed),
        .q     (lfsr_q_s)
    );

    // Palette is a power of two, so "low CW bits" equals "modulo N_COLORS";
    // the mask also keeps fixed-table indices inside a 2-colour palette.
    assign lfsr_col_s  = 3'(lfsr_q_s % LFSR_W'(N_COLORS));
    assign fixed_col_s = fixed_idx(4'(wr_idx_r)) & CMASK;
    assign wr_data_s   = gen_mode_r ? N_COLORS'(onehot(lfsr_col_s))
                                    : N_COLORS'(onehot(fixed_col_s));

    // Fill FSM: next state, write enable and completion pulse.
    always_comb begin
        gen_state_s  = gen_state_r;
        wr_idx_s     = wr_idx_r;
        gen_mode_s   = gen_mode_r;
        gen_done_s   = 1'b0;
        gen_accept_s = 1'b0;
        mem_we_s     = 1'b0;
        case (gen_state_r)
            G_IDLE: begin
                if (gen_start && (play_state_r == P_IDLE)) begin
                    gen_accept_s = 1'b1;
                    gen_state_s  = G_FILL;
                    wr_idx_s     = {AW{1'b0}};
                    gen_mode_s   = mode;
                end else begin
                    gen_state_s  = G_IDLE;
                end
            end
            G_FILL: begin
                mem_we_s = 1'b1;
                if (wr_idx_r == AW'(DEPTH - 1)) begin
                    gen_state_s = G_IDLE;
                    wr_idx_s    = {AW{1'b0}};
                    gen_done_s  = 1'b1;
                end else begin
                    wr_idx_s    = wr_idx_r + AW'(1);
                end
            end
            default: begin
                gen_state_s = G_IDLE;
                wr_idx_s    = {AW{1'b0}};
            end
        endcase
    end

    // Fill FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_state_r <= G_IDLE;
            wr_idx_r    <= {AW{1'b0}};
            gen_mode_r  <= 1'b0;
            gen_done_r  <= 1'b0;
        end else begin
            gen_state_r <= gen_state_s;
            wr_idx_r    <= wr_idx_s;
            gen_mode_r  <= gen_mode_s;
            gen_done_r  <= gen_done_s;
        end
    end

    // Sequence memory; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {N_COLORS{1'b0}};
            end
        end else if (mem_we_s) begin
            mem_r[wr_idx_r] <= wr_data_s;
        end
    end

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << AW)) begin : g_addr_full
            assign addr_ok_s = 1'b1;
        end else begin : g_addr_part
            assign addr_ok_s = ({1'b0, rd_addr} < DEPTH_L);
        end
    endgenerate

    assign gen_busy = (gen_state_r == G_FILL);
    assign gen_done = gen_done_r;
    assign rd_data  = (gen_busy || !addr_ok_s) ? {N_COLORS{1'b0}} : mem_r[rd_addr];

    assign step_inc_s   = step_r + AW'(1);
    assign next_count_s = {1'b0, step_r} + LW'(1);

    // Playback FSM: next state, step/timer bookkeeping and flash colour.
    always_comb begin
        play_state_s = play_state_r;
        step_s       = step_r;
        len_s        = len_r;
        timer_s      = timer_r;
        color_s      = color_r;
        play_done_s  = 1'b0;
        case (play_state_r)
            P_IDLE: begin
                // A gen_start accepted this same cycle takes precedence.
                if (play_start && !gen_busy && !gen_accept_s) begin
                    len_s  = (play_len > DEPTH_L) ? DEPTH_L : play_len;
                    step_s = {AW{1'b0}};
                    if (len_s == {LW{1'b0}}) begin
                        play_state_s = P_IDLE;
                        play_done_s  = 1'b1;
                    end else begin
                        play_state_s = P_ON;
                        timer_s      = TON_L;
                        color_s      = mem_r[{AW{1'b0}}];
                    end
                end else begin
                    play_state_s = P_IDLE;
                end
            end
            P_ON: begin
                if (timer_r == {TW{1'b0}}) begin
                    play_state_s = P_OFF;
                    timer_s      = TOFF_L;
                    color_s      = {N_COLORS{1'b0}};
                end else begin
                    timer_s      = timer_r - TW'(1);
                end
            end
            P_OFF: begin
                if (timer_r == {TW{1'b0}}) begin
                    if (next_count_s < len_r) begin
                        play_state_s = P_ON;
                        step_s       = step_inc_s;
                        timer_s      = TON_L;
                        color_s      = mem_r[step_inc_s];
                    end else begin
                        play_state_s = P_IDLE;
                        step_s       = {AW{1'b0}};
                        play_done_s  = 1'b1;
                    end
                end else begin
                    timer_s = timer_r - TW'(1);
                end
            end
            default: begin
                play_state_s = P_IDLE;
                step_s       = {AW{1'b0}};
                color_s      = {N_COLORS{1'b0}};
            end
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (play_stop) begin
            play_state_s = P_IDLE;
            step_s       = {AW{1'b0}};
            timer_s      = {TW{1'b0}};
            color_s      = {N_COLORS{1'b0}};
            play_done_s  = 1'b0;
        end else begin
            play_state_s = play_state_s;
        end
    end

    // Playback FSM state register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_state_r <= P_IDLE;
            step_r       <= {AW{1'b0}};
            len_r        <= {LW{1'b0}};
            timer_r      <= {TW{1'b0}};
            color_r      <= {N_COLORS{1'b0}};
            play_done_r  <= 1'b0;
        end else begin
            play_state_r <= play_state_s;
            step_r       <= step_s;
            len_r        <= len_s;
            timer_r      <= timer_s;
            color_r      <= color_s;
            play_done_r  <= play_done_s;
        end
    end

    assign play_busy  = (play_state_r != P_IDLE);
    assign play_color = color_r;
    assign play_step  = step_r;
    assign play_done  = play_done_r;

endmodule
